// File: rtl/note_cycle_scheduler.sv
// note_cycle_scheduler: sequences DFT frame snapshots into NoteFinder cycles
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   enable                        allows new launches and frame acceptance
//   frameReady                    one-cycle pulse, new dftBins snapshot
//   nfFinished                    NoteFinder done flag
//   clearErr                      clears the sticky timeout error
//   startCycle, binsFreeze        NoteFinder start pulse / hold dftBins stable
//   notesValid, busy              fresh-results pulse / not idle
//   timeoutErr                    sticky watchdog error
//   dropCount, lastCycles         saturating lost-frame count / last RUN length
module note_cycle_scheduler #(
  parameter int TIMEOUT = 300,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            frameReady,
  input  logic            nfFinished,
  input  logic            clearErr,
  output logic            startCycle,
  output logic            binsFreeze,
  output logic            notesValid,
  output logic            busy,
  output logic            timeoutErr,
  output logic [CNTW-1:0] dropCount,
  output logic [CNTW-1:0] lastCycles
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic pending_q, pending_d, err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [CNTW-1:0] drop_q, drop_d, last_q, last_d;
  logic start_q, freeze_q, valid_q, busy_q;
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    wd_d = wd_q;
    last_d = last_q;
    drop_d = drop_q;
    err_d = err_q & ~clearErr;
    case (state_q)
      IDLE: if (enable && (frameReady || pending_q)) begin
        state_d = LAUNCH;
        pending_d = 1'b0;
      end
      LAUNCH: begin
        state_d = RUN;
        wd_d = '0;
      end
      RUN: begin
        wd_d = wd_q + WDW'(1);
        // finishing on the last allowed cycle beats the watchdog
        if (nfFinished) begin
          state_d = DONE;
          last_d = CNTW'(wd_q) + CNTW'(1);
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // frames arriving while a cycle is in flight go to the single pending slot
    if (enable && frameReady && state_q != IDLE) begin
      pending_d = 1'b1;
      drop_d = (pending_q && drop_q != '1) ? drop_q + CNTW'(1) : drop_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      err_q <= 1'b0;
      wd_q <= '0;
      drop_q <= '0;
      last_q <= '0;
      start_q <= 1'b0;
      freeze_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      err_q <= err_d;
      wd_q <= wd_d;
      drop_q <= drop_d;
      last_q <= last_d;
      start_q <= state_d == LAUNCH;
      freeze_q <= state_d == LAUNCH || state_d == RUN;
      valid_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
    end
  end
  assign startCycle = start_q;
  assign binsFreeze = freeze_q;
  assign notesValid = valid_q;
  assign busy = busy_q;
  assign timeoutErr = err_q;
  assign dropCount = drop_q;
  assign lastCycles = last_q;
endmodule
